// File: rtl/fp_mul_iter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fp_mul_iter : iterative shift-add IEEE-754 style multiplier (RNE, flags)
// Revision    : 1.0
// ---------------------------------------------------------------------------
module fp_mul_iter #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   in_a,
  input  logic [EXP_W+MAN_W:0]   in_b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   out_result,
  output logic [3:0]             out_flags
);

  localparam int W     = 1 + EXP_W + MAN_W;
  localparam int P     = MAN_W + 1;
  localparam int PW    = 2 * P;
  localparam int EW    = EXP_W + 2;
  localparam int BIAS  = 2 ** (EXP_W - 1) - 1;
  localparam int EMAX  = 2 ** EXP_W - 1;
  localparam int SHMAX = 2 * MAN_W + 4;
  localparam int CW    = $clog2(P + 1);
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    MULT  = 3'd1,
    NORM  = 3'd2,
    ROUND = 3'd3,
    HOLD  = 3'd4
  } state_t;

  state_t state, state_nxt;

  logic                 sign;
  logic                 a_nan, a_snan, a_inf, a_zero;
  logic                 b_nan, b_snan, b_inf, b_zero;
  logic [EXP_W-1:0]     ea, eb;
  logic signed [EW-1:0] e;
  logic [PW-1:0]        mcand;
  logic [P-1:0]         mplier;
  logic [PW-1:0]        prod;
  logic                 sticky;
  logic [CW-1:0]        cnt;

  // operand unpacking
  logic [EXP_W-1:0] a_exp, b_exp;
  logic [MAN_W-1:0] a_frac, b_frac;
  logic             a_ez, b_ez, a_eo, b_eo;

  assign a_exp  = in_a[W-2:MAN_W];
  assign b_exp  = in_b[W-2:MAN_W];
  assign a_frac = in_a[MAN_W-1:0];
  assign b_frac = in_b[MAN_W-1:0];
  assign a_ez   = (a_exp == '0);
  assign b_ez   = (b_exp == '0);
  assign a_eo   = &a_exp;
  assign b_eo   = &b_exp;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == HOLD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = MULT;
      MULT:    if (cnt == CW'(P)) state_nxt = NORM;
      NORM:    state_nxt = ROUND;
      ROUND:   state_nxt = HOLD;
      HOLD:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // normalisation: leading one moved to the top bit, exponent clamped at 1,
  // then right shift into the subnormal range with sticky collection
  int                   n_lz, n_e1, n_sl, n_e2, n_sr;
  logic [PW-1:0]        n_shl, n_prod;
  logic                 n_stk;
  logic signed [EW-1:0] n_e;

  always_comb begin
    n_lz = PW;
    for (int i = 0; i < PW; i++)
      if (prod[i]) n_lz = PW - 1 - i;
    n_e1 = int'(e) + 1;
    n_sl = 0;
    if (n_e1 > 1) n_sl = (n_lz < n_e1 - 1) ? n_lz : n_e1 - 1;
    n_e2 = n_e1 - n_sl;
    n_sr = 0;
    if (n_e2 < 1) n_sr = (1 - n_e2 > SHMAX) ? SHMAX : 1 - n_e2;
    n_shl = prod << n_sl;
    n_stk = 1'b0;
    for (int i = 0; i < PW; i++)
      if (i < n_sr && n_shl[i]) n_stk = 1'b1;
    n_prod = n_shl >> n_sr;
    n_e    = n_prod[PW-1] ? EW'(n_e2) : '0;
  end

  // rounding and special-case resolution
  logic [P-1:0]     r_sig;
  logic             r_guard, r_stk, r_inc, r_inexact, r_tiny;
  logic [P:0]       r_sum;
  int               r_exp;
  logic [MAN_W-1:0] r_frac;
  logic [W-1:0]     r_res;
  logic [3:0]       r_flg;

  always_comb begin
    r_sig     = prod[PW-1:MAN_W+1];
    r_guard   = prod[MAN_W];
    r_stk     = (|prod[MAN_W-1:0]) | sticky;
    r_inc     = r_guard & (r_stk | r_sig[0]);
    r_sum     = {1'b0, r_sig} + (P+1)'(r_inc);
    r_inexact = r_guard | r_stk;
    r_tiny    = (e == '0);
    if (r_tiny) begin
      r_exp  = r_sum[MAN_W] ? 1 : 0;
      r_frac = r_sum[MAN_W-1:0];
    end else if (r_sum[P]) begin
      r_exp  = int'(e) + 1;
      r_frac = r_sum[MAN_W:1];
    end else begin
      r_exp  = int'(e);
      r_frac = r_sum[MAN_W-1:0];
    end

    if (a_nan | b_nan) begin
      r_res = QNAN;
      r_flg = {a_snan | b_snan, 3'b000};
    end else if ((a_inf & b_zero) | (a_zero & b_inf)) begin
      r_res = QNAN;
      r_flg = 4'b1000;
    end else if (a_inf | b_inf) begin
      r_res = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      r_flg = 4'b0000;
    end else if (a_zero | b_zero) begin
      r_res = {sign, {(W-1){1'b0}}};
      r_flg = 4'b0000;
    end else if (r_exp >= EMAX) begin
      r_res = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      r_flg = 4'b0101;
    end else begin
      r_res = {sign, EXP_W'(r_exp), r_frac};
      r_flg = {2'b00, r_tiny & r_inexact, r_inexact};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign       <= 1'b0;
      a_nan      <= 1'b0;
      a_snan     <= 1'b0;
      a_inf      <= 1'b0;
      a_zero     <= 1'b0;
      b_nan      <= 1'b0;
      b_snan     <= 1'b0;
      b_inf      <= 1'b0;
      b_zero     <= 1'b0;
      ea         <= '0;
      eb         <= '0;
      e          <= '0;
      mcand      <= '0;
      mplier     <= '0;
      prod       <= '0;
      sticky     <= 1'b0;
      cnt        <= '0;
      out_result <= '0;
      out_flags  <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          sign   <= in_a[W-1] ^ in_b[W-1];
          a_nan  <= a_eo & (a_frac != '0);
          a_snan <= a_eo & (a_frac != '0) & ~a_frac[MAN_W-1];
          a_inf  <= a_eo & (a_frac == '0);
          a_zero <= a_ez & (a_frac == '0);
          b_nan  <= b_eo & (b_frac != '0);
          b_snan <= b_eo & (b_frac != '0) & ~b_frac[MAN_W-1];
          b_inf  <= b_eo & (b_frac == '0);
          b_zero <= b_ez & (b_frac == '0);
          // subnormals: hidden bit 0, effective exponent 1
          ea     <= a_ez ? EXP_W'(1) : a_exp;
          eb     <= b_ez ? EXP_W'(1) : b_exp;
          mcand  <= PW'({~a_ez, a_frac});
          mplier <= {~b_ez, b_frac};
          prod   <= '0;
          sticky <= 1'b0;
          cnt    <= '0;
        end
        MULT: begin
          cnt <= cnt + CW'(1);
          if (cnt == '0) begin
            e <= EW'(ea) + EW'(eb) - EW'(BIAS);
          end else begin
            if (mplier[0]) prod <= prod + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
          end
        end
        NORM: begin
          prod   <= n_prod;
          e      <= n_e;
          sticky <= n_stk;
        end
        ROUND: begin
          out_result <= r_res;
          out_flags  <= r_flg;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fp_mul_iter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_fp_mul_iter : vector table + scoreboard bench for fp_mul_iter (FP16)
// Revision       : 1.0
// ---------------------------------------------------------------------------
module tb_fp_mul_iter;

  localparam int W   = 16;
  localparam int LAT = 14;
  localparam int NV  = 15;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out_result;
  logic [3:0]   out_flags;

  fp_mul_iter #(.EXP_W(5), .MAN_W(10)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_flags  (out_flags)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic [3:0]  flg;
  } vec_t;

  vec_t vecs [NV];
  vec_t sb [$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] res, input logic [3:0] flg);
    vec_t v;
    @(negedge clk);
    chk("in_ready_idle", 32'(in_ready), 1);
    in_a = a; in_b = b; in_valid = 1'b1;
    v = {a, b, res, flg};
    sb.push_back(v);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // entered at the negedge following the accepting edge
  task automatic collect(input string tag);
    int   lat;
    vec_t v;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), LAT);
    if (sb.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s_scoreboard: got an output, expected none", tag);
    end else begin
      v = sb.pop_front();
      chk({tag, "_result"}, 32'(out_result), 32'(v.res));
      chk({tag, "_flags"},  32'(out_flags),  32'(v.flg));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    vecs[0]  = {16'h3C00, 16'h3C00, 16'h3C00, 4'b0000};
    vecs[1]  = {16'h3E00, 16'hC100, 16'hC380, 4'b0000};
    vecs[2]  = {16'h3C01, 16'h3C01, 16'h3C02, 4'b0001};
    vecs[3]  = {16'h7BFF, 16'h4000, 16'h7C00, 4'b0101};
    vecs[4]  = {16'h7C00, 16'h0000, 16'h7E00, 4'b1000};
    vecs[5]  = {16'h7D00, 16'h3C00, 16'h7E00, 4'b1000};
    vecs[6]  = {16'h7E00, 16'h3C00, 16'h7E00, 4'b0000};
    vecs[7]  = {16'h8000, 16'h3C00, 16'h8000, 4'b0000};
    vecs[8]  = {16'h0400, 16'h3800, 16'h0200, 4'b0000};
    vecs[9]  = {16'h0001, 16'h3800, 16'h0000, 4'b0011};
    // 1.5 ulp of the smallest subnormal is a tie; even neighbour is 2 ulp
    vecs[10] = {16'h0001, 16'h3E00, 16'h0002, 4'b0011};
    vecs[11] = {16'hFC00, 16'h4000, 16'hFC00, 4'b0000};
    vecs[12] = {16'h03FF, 16'h3C00, 16'h03FF, 4'b0000};
    vecs[13] = {16'h0200, 16'h4000, 16'h0400, 4'b0000};
    vecs[14] = {16'h03FF, 16'h3C01, 16'h0400, 4'b0011};

    #1;
    chk("reset_in_ready",   32'(in_ready),   1);
    chk("reset_out_valid",  32'(out_valid),  0);
    chk("reset_out_result", 32'(out_result), 0);
    chk("reset_out_flags",  32'(out_flags),  0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      issue(vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].flg);
      collect($sformatf("vec%0d", i));
      @(negedge clk);
      chk($sformatf("vec%0d_valid_drop", i), 32'(out_valid), 0);
    end

    // backpressure: result held, new requests ignored
    out_ready = 1'b0;
    issue(16'h4200, 16'h4200, 16'h4880, 4'b0000);
    collect("bp");
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      in_valid = 1'b1; in_a = 16'h3C00; in_b = 16'h3C00;
      chk("bp_valid_held", 32'(out_valid),  1);
      chk("bp_result_held", 32'(out_result), 32'h4880);
      chk("bp_flags_held",  32'(out_flags),  0);
      chk("bp_in_ready",    32'(in_ready),   0);
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", 32'(out_valid), 0);
    chk("bp_release_ready", 32'(in_ready),  1);
    issue(16'h4400, 16'hBC00, 16'hC400, 4'b0000);
    collect("bp_next");

    // asynchronous reset during the multiply phase
    issue(16'h3C00, 16'h3C00, 16'h3C00, 4'b0000);
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid_valid",  32'(out_valid),  0);
    chk("rst_mid_ready",  32'(in_ready),   1);
    chk("rst_mid_result", 32'(out_result), 0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    issue(16'h4000, 16'h4000, 16'h4400, 4'b0000);
    collect("post_rst");
    @(negedge clk);
    begin
      int spur;
      spur = 0;
      for (int k = 0; k < LAT + 4; k++) begin
        @(negedge clk);
        if (out_valid) spur++;
      end
      chk("no_spurious_output", 32'(spur), 0);
    end
    chk("scoreboard_empty", 32'(sb.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
